// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly stage fed by the complex multiplier.
// Rescales the 48-bit twiddle product P = W*B to 24-bit samples.
// Forms X0 = A+P and X1 = A-P, with optional halving, in a 3-stage
// valid/ready pipeline. Saturation anywhere in the datapath sets a sticky ovf flag.
module fft_butterfly_stage #(
  parameter int FRAC     = 22,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_a,
  input  logic [95:0] in_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_x0,
  output logic [47:0] out_x1,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam logic signed [48:0] RND    = 49'sd1 <<< (FRAC - 1);
  localparam logic signed [48:0] PR_MAX = 49'sd8388607;
  localparam logic signed [48:0] PR_MIN = -49'sd8388608;
  localparam logic signed [25:0] X_MAX  = 26'sd8388607;
  localparam logic signed [25:0] X_MIN  = -26'sd8388608;

  // Round-half-up of one product component back to sample scale.
  // Returns {clipped, value}.
  function automatic logic [24:0] rescale(input logic [47:0] p);
    logic signed [48:0] t;
    t = $signed({p[47], p}) + RND;
    t = t >>> FRAC;
    if (t > PR_MAX)
      rescale = {1'b1, 24'h7fffff};
    else if (t < PR_MIN)
      rescale = {1'b1, 24'h800000};
    else
      rescale = {1'b0, t[23:0]};
  endfunction

  // Sum or difference of one component pair, optionally halved.
  // Returns {clipped, value}.
  function automatic logic [24:0] combine(input logic [23:0] a, input logic [23:0] b,
                                          input logic sub);
    logic signed [24:0] s;
    logic signed [25:0] w;
    if (sub)
      s = $signed({a[23], a}) - $signed({b[23], b});
    else
      s = $signed({a[23], a}) + $signed({b[23], b});
    w = $signed({s[24], s});
    if (SCALE_EN)
      w = (w + 26'sd1) >>> 1;
    if (w > X_MAX)
      combine = {1'b1, 24'h7fffff};
    else if (w < X_MIN)
      combine = {1'b1, 24'h800000};
    else
      combine = {1'b0, w[23:0]};
  endfunction

  logic        v1, v2;
  logic [47:0] s1_a;
  logic [95:0] s1_p;
  logic [47:0] s2_a;
  logic [47:0] s2_pr;
  logic        s2_sat;
  logic        ld1, ld2, ld3;

  logic [24:0] pr_re_c, pr_im_c;
  logic [24:0] x0_re_c, x0_im_c, x1_re_c, x1_im_c;
  logic        s3_sat_c;

  // A stage accepts new contents when it is empty or its successor takes its item.
  assign ld3      = ~out_valid | out_ready;
  assign ld2      = ~v2 | ld3;
  assign ld1      = ~v1 | ld2;
  assign in_ready = ld1;

  // S2 datapath: rescale and clip both product components.
  always_comb begin
    pr_re_c = rescale(s1_p[95:48]);
    pr_im_c = rescale(s1_p[47:0]);
  end

  // S3 datapath: butterfly add/sub with optional halving and clipping.
  always_comb begin
    x0_re_c  = combine(s2_a[47:24], s2_pr[47:24], 1'b0);
    x0_im_c  = combine(s2_a[23:0],  s2_pr[23:0],  1'b0);
    x1_re_c  = combine(s2_a[47:24], s2_pr[47:24], 1'b1);
    x1_im_c  = combine(s2_a[23:0],  s2_pr[23:0],  1'b1);
    s3_sat_c = x0_re_c[24] | x0_im_c[24] | x1_re_c[24] | x1_im_c[24];
  end

  // S1: capture raw operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      s1_a <= '0;
      s1_p <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_a <= in_a;
        s1_p <= in_p;
      end
    end
  end

  // S2: hold A alongside the rescaled product and its clip flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2     <= 1'b0;
      s2_a   <= '0;
      s2_pr  <= '0;
      s2_sat <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_a   <= s1_a;
        s2_pr  <= {pr_re_c[23:0], pr_im_c[23:0]};
        s2_sat <= pr_re_c[24] | pr_im_c[24];
      end
    end
  end

  // S3: output registers, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_x0    <= '0;
      out_x1    <= '0;
    end else if (ld3) begin
      out_valid <= v2;
      if (v2) begin
        out_x0 <= {x0_re_c[23:0], x0_im_c[23:0]};
        out_x1 <= {x1_re_c[23:0], x1_im_c[23:0]};
      end
    end
  end

  // Sticky overflow: set when a clipped item enters S3; a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (reset)
      ovf <= 1'b0;
    else if (ld3 & v2 & (s2_sat | s3_sat_c))
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Bench for fft_butterfly_stage: one unscaled and one scaled instance share the same stimulus.
module tb_fft_butterfly_stage;
  localparam int     FRAC = 22;
  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic [47:0] in_a = '0;
  logic [95:0] in_p = '0;
  logic        in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
  logic [47:0] x0_0, x1_0, x0_1, x1_1;

  fft_butterfly_stage #(.FRAC(FRAC), .SCALE_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_p(in_p), .out_valid(out_valid0), .out_ready(out_ready),
    .out_x0(x0_0), .out_x1(x1_0), .ovf(ovf0), .ovf_clr(ovf_clr));

  fft_butterfly_stage #(.FRAC(FRAC), .SCALE_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_p(in_p), .out_valid(out_valid1), .out_ready(out_ready),
    .out_x0(x0_1), .out_x1(x1_1), .ovf(ovf1), .ovf_clr(ovf_clr));

  typedef struct packed {
    logic [47:0] x0_0, x1_0, x0_1, x1_1;
    logic        sat0, sat1;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  bit          ovf_track = 0, sticky0 = 0, sticky1 = 0, prev_stall = 0;
  logic [47:0] prev_x0, prev_x1;
  bit          last_in_xfer = 0, last_in_ready = 1;
  int          last_inflight = 0, popped = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx24(input logic [23:0] v);
    return longint'({{40{v[23]}}, v});
  endfunction

  function automatic longint sx48(input logic [47:0] v);
    return longint'({{16{v[47]}}, v});
  endfunction

  function automatic longint clip(input longint v, inout bit sat);
    if (v > MAXV) begin sat = 1; return MAXV; end
    if (v < MINV) begin sat = 1; return MINV; end
    return v;
  endfunction

  // One component of the butterfly, straight from the arithmetic definition.
  function automatic void comp(input longint a, input longint p, input bit scale,
                               output longint x0, output longint x1, output bit sat);
    longint pr, s, d;
    sat = 0;
    pr = (p + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    pr = clip(pr, sat);
    s  = a + pr;
    d  = a - pr;
    if (scale) begin
      s = (s + 1) >>> 1;
      d = (d + 1) >>> 1;
    end
    x0 = clip(s, sat);
    x1 = clip(d, sat);
  endfunction

  function automatic exp_t model(input logic [47:0] a, input logic [95:0] p);
    exp_t   e;
    longint r0, r1, i0, i1;
    bit     sr, si;
    comp(sx24(a[47:24]), sx48(p[95:48]), 1'b0, r0, r1, sr);
    comp(sx24(a[23:0]),  sx48(p[47:0]),  1'b0, i0, i1, si);
    e.x0_0 = {r0[23:0], i0[23:0]};
    e.x1_0 = {r1[23:0], i1[23:0]};
    e.sat0 = sr | si;
    comp(sx24(a[47:24]), sx48(p[95:48]), 1'b1, r0, r1, sr);
    comp(sx24(a[23:0]),  sx48(p[47:0]),  1'b1, i0, i1, si);
    e.x0_1 = {r0[23:0], i0[23:0]};
    e.x1_1 = {r1[23:0], i1[23:0]};
    e.sat1 = sr | si;
    return e;
  endfunction

  // One clock: observe at the falling edge, update the scoreboard, return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_in_xfer  = 0;
    last_in_ready = in_ready0;
    last_inflight = q.size();
    if (!reset) begin
      chk("in_ready_match", in_ready1, in_ready0);
      chk("out_valid_match", out_valid1, out_valid0);
      if (prev_stall) begin
        chk("stall_hold_x0", x0_0, prev_x0);
        chk("stall_hold_x1", x1_0, prev_x1);
      end
      if (out_valid0) begin
        if (q.size() == 0) chk("spurious_out", out_valid0, 0);
        else begin
          e = q[0];
          chk("x0_noscale", x0_0, e.x0_0);
          chk("x1_noscale", x1_0, e.x1_0);
          chk("x0_scale", x0_1, e.x0_1);
          chk("x1_scale", x1_1, e.x1_1);
          if (ovf_track) begin
            chk("ovf_noscale", ovf0, sticky0 | e.sat0);
            chk("ovf_scale", ovf1, sticky1 | e.sat1);
          end
          if (out_ready) begin
            sticky0 |= e.sat0;
            sticky1 |= e.sat1;
            void'(q.pop_front());
            popped++;
          end
        end
      end
      prev_stall = out_valid0 & ~out_ready;
      prev_x0    = x0_0;
      prev_x1    = x1_0;
      if (in_valid & in_ready0) begin
        q.push_back(model(in_a, in_p));
        last_in_xfer = 1;
      end
    end else prev_stall = 0;
    @(posedge clk);
    #1;
  endtask

  // Push one item into an empty pipeline and capture its result.
  task automatic run_one(input logic [47:0] a, input logic [95:0] p,
                         output logic [47:0] r00, output logic [47:0] r10,
                         output logic [47:0] r01, output logic [47:0] r11, output int lat);
    in_a = a; in_p = p; in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    lat = 1;
    while (!out_valid0 && lat < 10) begin
      cycle();
      lat++;
    end
    r00 = x0_0; r10 = x1_0; r01 = x0_1; r11 = x1_1;
    cycle();
  endtask

  function automatic logic [95:0] pk_p(input longint re, input longint im);
    return {re[47:0], im[47:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] r00, r10, r01, r11;
    logic [47:0] sat_a;
    logic [95:0] sat_p;
    logic [47:0] bp_a[20];
    logic [95:0] bp_p[20];
    longint      pv;
    longint      rnd_p[4];
    logic [23:0] rnd_x0[4];
    int          lat, bp_i, bp_cyc, blocked;

    rnd_p[0] = longint'(1) <<< 21;      rnd_x0[0] = 24'h000001;
    rnd_p[1] = (longint'(1) <<< 21) - 1; rnd_x0[1] = 24'h000000;
    rnd_p[2] = -(longint'(1) <<< 21);   rnd_x0[2] = 24'h000000;
    rnd_p[3] = -(longint'(1) <<< 21) - 1; rnd_x0[3] = 24'hffffff;
    sat_a = {24'h7fffff, 24'h000000};
    sat_p = pk_p(longint'(24'h400000) <<< 22, 0);

    // Reset with input activity that must be ignored.
    reset = 1; in_valid = 1; in_a = 48'h123456_654321; in_p = '1;
    repeat (3) cycle();
    reset = 0; in_valid = 0;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_x0", x0_0, 0);
    chk("rst_x1", x1_0, 0);
    chk("rst_in_ready", in_ready0, 1);

    // Basic butterfly, both scaling modes.
    run_one({24'h400000, 24'h0}, pk_p(longint'(1) <<< 43, 0), r00, r10, r01, r11, lat);
    chk("latency", lat, 3);
    chk("basic_x0", r00, {24'h600000, 24'h0});
    chk("basic_x1", r10, {24'h200000, 24'h0});
    chk("basic_x0_scaled", r01, {24'h300000, 24'h0});
    chk("basic_x1_scaled", r11, {24'h100000, 24'h0});
    chk("basic_ovf", ovf0, 0);
    chk("basic_ovf_scaled", ovf1, 0);

    // Round-half-up boundaries of the product rescale.
    for (int k = 0; k < 4; k++) begin
      run_one('0, pk_p(rnd_p[k], 0), r00, r10, r01, r11, lat);
      chk("round_x0re", r00[47:24], rnd_x0[k]);
    end

    // Saturation of the unscaled sum.
    run_one(sat_a, sat_p, r00, r10, r01, r11, lat);
    chk("sat_x0re", r00[47:24], 24'h7fffff);
    chk("sat_x1re", r10[47:24], 24'h3fffff);
    chk("sat_ovf", ovf0, 1);
    chk("sat_ovf_scaled", ovf1, 0);
    repeat (2) cycle();
    chk("ovf_sticky", ovf0, 1);

    // Clear in the same cycle a new clipped item enters S3: the set wins.
    in_a = sat_a; in_p = sat_p; in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    ovf_clr = 1;
    cycle();
    ovf_clr = 0;
    chk("ovf_set_wins", ovf0, 1);
    cycle();
    chk("ovf_after_set_wins", ovf0, 1);
    ovf_clr = 1;
    cycle();
    ovf_clr = 0;
    chk("ovf_cleared", ovf0, 0);
    chk("ovf_cleared_scaled", ovf1, 0);

    // Backpressure: 20 back-to-back items, consumer stalls in cycles 5..9.
    for (int k = 0; k < 20; k++) begin
      bp_a[k] = {$urandom, $urandom};
      pv      = longint'({$urandom, $urandom}) >>> 18;
      bp_p[k] = pk_p(pv, longint'({$urandom, $urandom}) >>> 18);
    end
    bp_i = 0; bp_cyc = 0; blocked = 0; popped = 0;
    while ((bp_i < 20 || q.size() != 0) && bp_cyc < 100) begin
      in_valid  = (bp_i < 20);
      in_a      = bp_a[bp_i < 20 ? bp_i : 19];
      in_p      = bp_p[bp_i < 20 ? bp_i : 19];
      out_ready = !(bp_cyc >= 5 && bp_cyc <= 9);
      cycle();
      if (!last_in_ready) begin
        blocked++;
        chk("bp_items_held", last_inflight, 3);
      end
      if (last_in_xfer) bp_i++;
      bp_cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_in_ready_dropped", blocked != 0, 1);
    chk("bp_all_out", popped, 20);

    // Randomized traffic with random stalls; ovf tracked from a cleared state.
    ovf_clr = 1;
    cycle();
    ovf_clr = 0;
    sticky0 = 0; sticky1 = 0; ovf_track = 1;
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = {$urandom, $urandom};
      pv        = longint'({$urandom, $urandom}) >>> $urandom_range(16, 20);
      in_p      = pk_p(pv, longint'({$urandom, $urandom}) >>> $urandom_range(16, 20));
      cycle();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 20 && q.size() != 0; k++) cycle();
    chk("drain_empty", q.size(), 0);
    ovf_track = 0;

    // Reset with three clipped items in flight.
    in_a = sat_a; in_p = sat_p; in_valid = 1;
    repeat (3) cycle();
    chk("pre_rst_ovf", ovf0, 1);
    chk("pre_rst_out_valid", out_valid0, 1);
    reset = 1;
    cycle();
    reset = 0; in_valid = 0;
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_ovf", ovf0, 0);
    chk("midrst_in_ready", in_ready0, 1);
    chk("midrst_x0", x0_0, 0);
    q.delete();
    prev_stall = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("no_stale_item", out_valid0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
